// File: rtl/pes_r2_4bm_pkg.sv
// pes_r2_4bm_pkg: shared types, widths and helpers for the multiplier sequencer/accumulator
package pes_r2_4bm_pkg;
   localparam int PROD_W = 8;
   localparam int OPND_W = 4;
   typedef enum logic [2:0] {IDLE, MRST, MLOAD, RUN, CAPT, OUT} state_t;
   function automatic logic [31:0] sext_prod(input logic [PROD_W-1:0] p);
      return {{(32-PROD_W){p[PROD_W-1]}}, p};
   endfunction
endpackage

// File: rtl/pes_acc_sat_chk.sv
// pes_acc_sat_chk: wrapping W-bit adder with signed-overflow detect
module pes_acc_sat_chk #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         ovf
);
   assign sum = a + b;
   assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/pes_r2_4bm_mac.sv
// pes_r2_4bm_mac: sequences pes_r2_4bm per operand pair and accumulates signed products
module pes_r2_4bm_mac
   import pes_r2_4bm_pkg::*;
#(
   parameter int ACC_W     = 16,
   parameter int MUL_STEPS = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPND_W-1:0] in_m,
   input  logic [OPND_W-1:0] in_q,
   input  logic              in_last,
   output logic              mul_reset,
   output logic              mul_load,
   output logic [OPND_W-1:0] mul_m,
   output logic [OPND_W-1:0] mul_q,
   input  logic [PROD_W-1:0] mul_p,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_ovf
);
   localparam int CW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [OPND_W-1:0] m_r, q_r;
   logic last_r;
   logic [ACC_W-1:0] acc, addend, sum;
   logic ovf, add_ovf;
   assign addend    = ACC_W'(sext_prod(mul_p));
   assign in_ready  = state == IDLE;
   assign out_valid = state == OUT;
   assign mul_reset = reset | (state == MRST);
   assign mul_load  = state == MLOAD;
   assign mul_m     = m_r;
   assign mul_q     = q_r;
   assign acc_out   = acc;
   assign acc_ovf   = ovf;
   pes_acc_sat_chk #(.W(ACC_W)) u_add (
      .a(acc),
      .b(addend),
      .sum(sum),
      .ovf(add_ovf)
   );
   // next-state: one pass through reset/load/run/capture per pair, OUT holds until taken
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? MRST : IDLE;
         MRST:    state_nx = MLOAD;
         MLOAD:   state_nx = RUN;
         RUN:     state_nx = (cnt == CW'(MUL_STEPS - 1)) ? CAPT : RUN;
         CAPT:    state_nx = last_r ? OUT : IDLE;
         OUT:     state_nx = out_ready ? IDLE : OUT;
         default: state_nx = IDLE;
      endcase
   end
   // state, operand latch, run counter and accumulator; the result clears once handed off
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         m_r    <= '0;
         q_r    <= '0;
         last_r <= 1'b0;
         acc    <= '0;
         ovf    <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            m_r    <= in_m;
            q_r    <= in_q;
            last_r <= in_last;
         end
         if (state == MLOAD) cnt <= '0;
         if (state == RUN) cnt <= cnt + 1'b1;
         if (state == CAPT) begin
            acc <= sum;
            ovf <= ovf | add_ovf;
         end
         if (state == OUT && out_ready) begin
            acc <= '0;
            ovf <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pes_r2_4bm_mac.sv
// tb_pes_r2_4bm_mac: table-driven and scoreboarded checks of the MAC sequencer with a behavioural multiplier
module tb_pes_r2_4bm_mac;
   localparam int MUL_STEPS = 4;
   logic clk = 0, reset = 1;
   logic in_valid = 0, in_last = 0, out_ready = 0;
   logic [3:0] in_m = 0, in_q = 0;
   logic in_ready, mul_reset, mul_load, out_valid, acc_ovf;
   logic [3:0] mul_m, mul_q;
   logic [7:0] mul_p;
   logic [15:0] acc_out;
   logic v8 = 0, l8 = 0, ordy8 = 0;
   logic [3:0] m8 = 0, q8 = 0;
   logic rdy8, mrst8, mld8, ov8, ovf8;
   logic [3:0] mm8o, mq8o;
   logic [7:0] mp8;
   logic [7:0] acc8;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   pes_r2_4bm_mac #(.ACC_W(16), .MUL_STEPS(MUL_STEPS)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_m(in_m), .in_q(in_q), .in_last(in_last),
      .mul_reset(mul_reset), .mul_load(mul_load), .mul_m(mul_m), .mul_q(mul_q),
      .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
      .acc_out(acc_out), .acc_ovf(acc_ovf)
   );

   pes_r2_4bm_mac #(.ACC_W(8), .MUL_STEPS(MUL_STEPS)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
      .in_m(m8), .in_q(q8), .in_last(l8),
      .mul_reset(mrst8), .mul_load(mld8), .mul_m(mm8o), .mul_q(mq8o),
      .mul_p(mp8), .out_valid(ov8), .out_ready(ordy8),
      .acc_out(acc8), .acc_ovf(ovf8)
   );

   // behavioural multipliers: product valid only MUL_STEPS cycles after load, junk before
   logic signed [7:0] a0, b0, a1, b1;
   int c0, c1;
   always @(posedge clk) begin
      if (mul_reset) begin
         c0 <= 0; mul_p <= 8'hA5;
      end else if (mul_load) begin
         c0 <= 0; mul_p <= 8'hA5; a0 <= $signed(mul_m); b0 <= $signed(mul_q);
      end else if (c0 < MUL_STEPS) begin
         c0 <= c0 + 1;
         if (c0 == MUL_STEPS - 1) mul_p <= a0 * b0;
      end
   end
   always @(posedge clk) begin
      if (mrst8) begin
         c1 <= 0; mp8 <= 8'hA5;
      end else if (mld8) begin
         c1 <= 0; mp8 <= 8'hA5; a1 <= $signed(mm8o); b1 <= $signed(mq8o);
      end else if (c1 < MUL_STEPS) begin
         c1 <= c1 + 1;
         if (c1 == MUL_STEPS - 1) mp8 <= a1 * b1;
      end
   end

   typedef struct {
      logic [15:0] acc;
      logic        ovf;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic [3:0]  m;
      logic [3:0]  q;
      logic        last;
      logic [15:0] exp_acc;
      logic        exp_ovf;
   } vec_t;
   vec_t tbl[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pair(input logic [3:0] m, input logic [3:0] q, input logic l);
      int n = 0;
      in_m = m; in_q = q; in_last = l; in_valid = 1;
      while (!in_ready && n < 100) begin tick(); n++; end
      check("accept_timeout", 32'(n < 100), 1);
      tick();
      in_valid = 0;
      check("busy_after_accept", 32'(in_ready), 0);
   endtask

   task automatic recv();
      int n = 0;
      exp_t e;
      while (!out_valid && n < 100) begin tick(); n++; end
      check("result_timeout", 32'(n < 100), 1);
      if (sbq.size() == 0) begin
         check("scoreboard_empty", 0, 1);
      end else begin
         e = sbq.pop_front();
         check("acc_out", 32'(acc_out), 32'(e.acc));
         check("acc_ovf", 32'(acc_ovf), 32'(e.ovf));
      end
      out_ready = 1;
      tick();
      out_ready = 0;
      check("acc_cleared", 32'(acc_out), 0);
      check("ready_after_out", 32'(in_ready), 1);
   endtask

   initial begin
      int n;
      tbl[0] = '{4'd3,  4'hE, 1'b1, 16'hFFFA, 1'b0};
      tbl[1] = '{4'd2,  4'd3, 1'b0, 16'h0000, 1'b0};
      tbl[2] = '{4'hC,  4'd5, 1'b0, 16'h0000, 1'b0};
      tbl[3] = '{4'd7,  4'd7, 1'b1, 16'h0023, 1'b0};
      tbl[4] = '{4'hF,  4'hF, 1'b0, 16'h0000, 1'b0};
      tbl[5] = '{4'h8,  4'd7, 1'b1, 16'hFFC9, 1'b0};
      tbl[6] = '{4'd7,  4'h8, 1'b1, 16'hFFC8, 1'b0};
      tbl[7] = '{4'd0,  4'd5, 1'b1, 16'h0000, 1'b0};
      tbl[8] = '{4'hD,  4'hD, 1'b0, 16'h0000, 1'b0};
      tbl[9] = '{4'd6,  4'h9, 1'b1, 16'hFFDF, 1'b0};

      repeat (3) tick();
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_acc", 32'(acc_out), 0);
      check("rst_ovf", 32'(acc_ovf), 0);
      check("rst_mul_reset", 32'(mul_reset), 1);
      check("rst_mul_m", 32'(mul_m), 0);
      reset = 0;
      tick();
      check("idle_mul_reset", 32'(mul_reset), 0);

      // single pair with cycle-accurate protocol, busy in_valid and held result
      in_m = 4'd3; in_q = 4'hE; in_last = 1; in_valid = 1;
      tick();
      in_m = 4'd5; in_q = 4'd6; in_last = 0;
      check("mrst_ready", 32'(in_ready), 0);
      check("mrst_pulse", 32'(mul_reset), 1);
      check("mrst_load", 32'(mul_load), 0);
      tick();
      check("mload_pulse", 32'(mul_load), 1);
      check("mload_reset", 32'(mul_reset), 0);
      for (int i = 0; i < MUL_STEPS; i++) begin
         tick();
         check("run_load", 32'(mul_load), 0);
         check("run_ready", 32'(in_ready), 0);
         check("run_mul_m", 32'(mul_m), 3);
         check("run_mul_q", 32'(mul_q), 32'hE);
      end
      tick();
      check("capt_out_valid", 32'(out_valid), 0);
      tick();
      in_valid = 0;
      check("out_valid", 32'(out_valid), 1);
      check("out_acc", 32'(acc_out), 32'hFFFA);
      check("out_ovf", 32'(acc_ovf), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_valid", 32'(out_valid), 1);
         check("hold_acc", 32'(acc_out), 32'hFFFA);
         check("hold_ready", 32'(in_ready), 0);
      end
      out_ready = 1;
      tick();
      out_ready = 0;
      check("taken_acc", 32'(acc_out), 0);
      check("taken_ready", 32'(in_ready), 1);
      check("taken_valid", 32'(out_valid), 0);

      // table-driven vectors through the scoreboard
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].last) sbq.push_back('{tbl[i].exp_acc, tbl[i].exp_ovf});
         send_pair(tbl[i].m, tbl[i].q, tbl[i].last);
         if (tbl[i].last) recv();
      end

      // reset during RUN of the second pair discards the partial sum
      send_pair(4'd5, 4'd5, 1'b0);
      n = 0;
      while (!in_ready && n < 100) begin tick(); n++; end
      check("partial_timeout", 32'(n < 100), 1);
      check("partial_acc", 32'(acc_out), 32'h19);
      send_pair(4'd1, 4'd2, 1'b0);
      repeat (3) tick();
      reset = 1;
      #1;
      check("rst_run_mul_reset", 32'(mul_reset), 1);
      tick();
      reset = 0;
      check("rst_run_idle", 32'(in_ready), 1);
      check("rst_run_acc", 32'(acc_out), 0);
      check("rst_run_valid", 32'(out_valid), 0);
      sbq.push_back('{16'h0001, 1'b0});
      send_pair(4'd1, 4'd1, 1'b1);
      recv();

      // 8-bit accumulator wraps on the third 49
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!rdy8 && n < 100) begin tick(); n++; end
         check("acc8_accept_timeout", 32'(n < 100), 1);
         if (k == 2) begin
            check("acc8_mid", 32'(acc8), 32'h62);
            check("acc8_mid_ovf", 32'(ovf8), 0);
         end
         m8 = 4'd7; q8 = 4'd7; l8 = (k == 2); v8 = 1;
         tick();
         v8 = 0;
      end
      n = 0;
      while (!ov8 && n < 100) begin tick(); n++; end
      check("acc8_result_timeout", 32'(n < 100), 1);
      check("acc8_wrap", 32'(acc8), 32'h93);
      check("acc8_ovf", 32'(ovf8), 1);
      ordy8 = 1;
      tick();
      ordy8 = 0;
      check("acc8_ovf_cleared", 32'(ovf8), 0);
      check("acc8_cleared", 32'(acc8), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
